mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped 16-bit down-counter timer on the CPU data-memory bus (mem_cmd/mem_addr/write_data/read_data).
//  Sits beside RAM and the SW/LED I/O in the top level, decoding its own 9-bit addresses in the I/O space (mem_addr[8]=1).
//  Drives the shared read_data bus through a tri-state, like RAM and the switch port.
//  Gives software a periodic or one-shot time base, with a sticky expiry flag and an irq output (e.g. wired to LEDR[9]).
// PARAMETERS
//  BASE_ADDR  9'h180  word address of CTRL; LOAD=+1, COUNT=+2, STATUS=+3; must be 4-aligned, mem_addr[8]=1
//  PRESCALE   16'd1000  clk cycles per count tick; legal range 1..65535
// PORTS
//  clk         in   1   rising-edge clock, the CPU clock
//  reset       in   1   asynchronous, active-low (0 = reset)
//  mem_cmd     in   2   2'b00 none, 2'b01 read, 2'b10 write
//  mem_addr    in   9   CPU word address
//  write_data  in   16  CPU store data
//  read_data   out  16  tri-state; driven only on a decoded read, else 16'bz
//  irq         out  1   expired & CTRL.IRQ_EN
// BEHAVIOUR
//  Registers:
//   - CTRL[2:0] = {IRQ_EN, AUTO, EN}; bits 15:3 read 0.
//   - LOAD[15:0] read/write.
//   - COUNT[15:0] read-only; writes are ignored.
//   - STATUS[0] = expired (sticky); write 1 to clear, write 0 has no effect; bits 15:1 read 0.
//  Reset (async assert, clk-synchronous release): CTRL=0, LOAD=0, COUNT=0, expired=0, prescaler=0, state=IDLE.
//   irq=0 and read_data=z while reset is asserted.
//  Decode:
//   - sel = (mem_addr[8:2]==BASE_ADDR[8:2]); offset = mem_addr[1:0].
//   - Addresses outside the 4-word window: no effect, read_data=z.
//  Reads: combinational, zero latency. Value is valid in the same cycle mem_cmd=01 with sel=1 (pre-edge register state).
//  Writes: take effect at the rising clk edge where mem_cmd=10 and sel=1.
//  Writing LOAD also sets COUNT=write_data and prescaler=0 on that same edge. It does not change expired.
//  Prescaler:
//   - Counts 0..PRESCALE-1 only while EN=1; otherwise it holds.
//   - tick=1 on the cycle it equals PRESCALE-1; it then wraps to 0.
//   - PRESCALE=1 gives a tick every cycle.
//  FSM (state exported in no port; observable via COUNT and expired):
//   - IDLE: EN=0. COUNT and prescaler hold. Goes to RUN when EN is written 1 and COUNT!=0, or to HOLD when EN is written 1 and COUNT==0.
//   - RUN: on tick, if COUNT>1 then COUNT-=1.
//     If COUNT==1: expired<=1; with AUTO=1, COUNT<=LOAD (stay in RUN, or go to HOLD if LOAD==0); with AUTO=0, COUNT<=0 and go to HOLD.
//   - HOLD: COUNT stays at 0 and expired holds. A LOAD write with data!=0 while EN=1 goes to RUN.
//   - Any state: writing EN=0 goes to IDLE next cycle and preserves COUNT.
//  Boundary and simultaneous events:
//   - Expiry in the same cycle as a STATUS write-1 clear: set wins, expired=1.
//   - LOAD write in the same cycle as a tick: the write wins and the tick is discarded.
//   - CTRL write EN 1->0 in the same cycle as a tick: the tick is discarded.
//   - COUNT never wraps below 0. A LOAD write of 0 while running gives HOLD with no expiry.
//   - Reset mid-count aborts immediately; everything returns to reset values.
//  irq is registered state gated combinationally: irq = expired & IRQ_EN. It can rise one cycle after the expiry tick.
// TESTING
//  1 Reset: reset=0 mid-run -> COUNT=0, CTRL=0, irq=0, read_data=z immediately (async), all remain 0 after release.
//  2 One-shot: PRESCALE=4, LOAD<=3, CTRL<=3'b101 -> COUNT reads 2,1,0 at 4-cycle steps; expired=1 and irq=1 after the 12th enabled cycle; COUNT then holds at 0.
//  3 Auto-reload: LOAD<=2, CTRL<=3'b011 -> COUNT sequence 2,1,2,1,... with expired set at the first wrap; write STATUS=1 clears it and the next wrap sets it again.
//  4 Collision: issue STATUS=1 on the exact expiry-tick cycle -> expired reads 1. Issue a LOAD write of 7 on a tick cycle -> COUNT=7, not 6.
//  5 Decode/bus: read 9'h140 and 9'h184 -> read_data=z from this block. Read BASE+2 -> COUNT with bits correct in the same cycle. Write BASE+2 -> COUNT unchanged.
//  6 Pause: EN<=0 at COUNT=5 -> COUNT holds 5 for 20 cycles; EN<=1 -> resumes to 4 after PRESCALE ticks; PRESCALE=1 gives decrement every cycle.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped 16-bit down-counter timer with a prescaler, auto-reload and a sticky expiry flag.
// Registers at BASE_ADDR+0..3: CTRL {IRQ_EN, AUTO, EN}, LOAD, COUNT (read-only), STATUS (expired, write-1-to-clear).
module mmio_timer #(
  parameter logic [8:0]  BASE_ADDR = 9'h180,
  parameter logic [15:0] PRESCALE  = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output tri   [15:0] read_data,
  output logic        irq
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ctrl_q;
  logic [15:0] load_q;
  logic [15:0] count_q;
  logic [15:0] presc_q;
  logic        expired_q;

  logic        sel, rd_en, wr_en;
  logic        wr_ctrl, wr_load, wr_status, en_off;
  logic        tick, run_tick;
  logic        count_dec, expire;
  logic [15:0] rd_val;

  // Bus decode: a 4-word window, offset in the two low address bits.
  assign sel       = (mem_addr[8:2] == BASE_ADDR[8:2]);
  assign rd_en     = reset & sel & (mem_cmd == CMD_READ);
  assign wr_en     = sel & (mem_cmd == CMD_WRITE);
  assign wr_ctrl   = wr_en & (mem_addr[1:0] == 2'd0);
  assign wr_load   = wr_en & (mem_addr[1:0] == 2'd1);
  assign wr_status = wr_en & (mem_addr[1:0] == 2'd3);
  assign en_off    = wr_ctrl & ~write_data[0];

  assign tick = ctrl_q[0] & (presc_q == PRESCALE - 16'd1);
  // A LOAD write or an EN-off write on the tick cycle discards the tick.
  assign run_tick = (state_q == RUN) & tick & ~wr_load & ~en_off;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en_off) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_ctrl && write_data[0]) begin
            state_d = (count_q != 16'd0) ? RUN : HOLD;
          end
        end
        RUN: begin
          if (wr_load) begin
            state_d = (write_data != 16'd0) ? RUN : HOLD;
          end else if (expire) begin
            state_d = (ctrl_q[1] && load_q != 16'd0) ? RUN : HOLD;
          end
        end
        HOLD: begin
          if (wr_load && write_data != 16'd0 && ctrl_q[0]) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: counter actions decided by the current state
  always_comb begin
    count_dec = 1'b0;
    expire    = 1'b0;
    if (run_tick) begin
      count_dec = (count_q > 16'd1);
      expire    = (count_q == 16'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= 3'd0;
      load_q    <= 16'd0;
      count_q   <= 16'd0;
      presc_q   <= 16'd0;
      expired_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= write_data[2:0];
      end
      if (wr_load) begin
        load_q <= write_data;
      end

      if (wr_load) begin
        count_q <= write_data;
      end else if (count_dec) begin
        count_q <= count_q - 16'd1;
      end else if (expire) begin
        count_q <= ctrl_q[1] ? load_q : 16'd0;
      end

      // Expiry takes priority over a same-cycle clear.
      if (expire) begin
        expired_q <= 1'b1;
      end else if (wr_status && write_data[0]) begin
        expired_q <= 1'b0;
      end

      if (wr_load || tick) begin
        presc_q <= 16'd0;
      end else if (ctrl_q[0]) begin
        presc_q <= presc_q + 16'd1;
      end
    end
  end

  always_comb begin
    rd_val = 16'd0;
    case (mem_addr[1:0])
      2'd0: rd_val = {13'd0, ctrl_q};
      2'd1: rd_val = load_q;
      2'd2: rd_val = count_q;
      2'd3: rd_val = {15'd0, expired_q};
      default: rd_val = 16'd0;
    endcase
  end

  assign read_data = rd_en ? rd_val : 16'bz;
  assign irq       = expired_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: instance A (base 9'h180, PRESCALE 4) and instance B (base 9'h1C0, PRESCALE 1).
// A bench-side driver puts 16'h5A5A on a bus only when checking that the timer leaves it undriven.
module tb_mmio_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic        keep;
  logic        irq_a, irq_b;
  tri   [15:0] rd_a, rd_b;

  int n_tests;
  int n_fail;

  assign rd_a = keep ? 16'h5A5A : 16'bz;
  assign rd_b = keep ? 16'h5A5A : 16'bz;

  mmio_timer #(.BASE_ADDR(9'h180), .PRESCALE(16'd4)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (rd_a),
    .irq        (irq_a)
  );

  mmio_timer #(.BASE_ADDR(9'h1C0), .PRESCALE(16'd1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (rd_b),
    .irq        (irq_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] data);
    mem_addr   = addr;
    write_data = data;
    mem_cmd    = 2'b10;
    @(posedge clk);
    #1;
    mem_cmd    = 2'b00;
  endtask

  task automatic chk_rd(input string tag, input logic [8:0] addr, input logic [15:0] exp);
    logic [15:0] val;
    mem_addr = addr;
    mem_cmd  = 2'b01;
    #1;
    val = addr[6] ? rd_b : rd_a;
    mem_cmd  = 2'b00;
    check(tag, val, exp);
  endtask

  task automatic chk_undriven(input string tag, input logic [8:0] addr);
    keep     = 1'b1;
    mem_addr = addr;
    mem_cmd  = 2'b01;
    #1;
    check({tag, "_a"}, rd_a, 16'h5A5A);
    check({tag, "_b"}, rd_b, 16'h5A5A);
    mem_cmd  = 2'b00;
    keep     = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    keep       = 1'b0;
    mem_cmd    = 2'b00;
    mem_addr   = 9'd0;
    write_data = 16'd0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Reset values
    chk_rd("rst_ctrl",   9'h180, 16'h0000);
    chk_rd("rst_load",   9'h181, 16'h0000);
    chk_rd("rst_count",  9'h182, 16'h0000);
    chk_rd("rst_status", 9'h183, 16'h0000);
    check("rst_irq", {15'd0, irq_a}, 16'd0);

    // PRESCALE=1 instance: one decrement per cycle
    wr(9'h1C1, 16'd3);
    wr(9'h1C0, 16'h0001);
    chk_rd("b_count3", 9'h1C2, 16'd3);
    step();
    chk_rd("b_count2", 9'h1C2, 16'd2);
    step();
    chk_rd("b_count1", 9'h1C2, 16'd1);
    step();
    chk_rd("b_count0", 9'h1C2, 16'd0);
    chk_rd("b_expired", 9'h1C3, 16'd1);
    check("b_irq_off", {15'd0, irq_b}, 16'd0);
    chk_rd("a_untouched", 9'h182, 16'd0);

    // One-shot on A
    wr(9'h181, 16'd3);
    wr(9'h180, 16'h0005);
    repeat (3) step();
    chk_rd("os_count3", 9'h182, 16'd3);
    step();
    chk_rd("os_count2", 9'h182, 16'd2);
    repeat (4) step();
    chk_rd("os_count1", 9'h182, 16'd1);
    check("os_irq_pre", {15'd0, irq_a}, 16'd0);
    repeat (4) step();
    chk_rd("os_count0", 9'h182, 16'd0);
    chk_rd("os_expired", 9'h183, 16'd1);
    check("os_irq", {15'd0, irq_a}, 16'd1);
    repeat (8) step();
    chk_rd("os_hold0", 9'h182, 16'd0);
    wr(9'h183, 16'd0);
    chk_rd("st_w0_noclr", 9'h183, 16'd1);
    wr(9'h183, 16'd1);
    chk_rd("st_w1_clr", 9'h183, 16'd0);
    check("os_irq_clr", {15'd0, irq_a}, 16'd0);

    // Auto-reload
    wr(9'h180, 16'h0000);
    wr(9'h181, 16'd2);
    wr(9'h180, 16'h0003);
    chk_rd("ar_count2", 9'h182, 16'd2);
    repeat (4) step();
    chk_rd("ar_count1", 9'h182, 16'd1);
    repeat (4) step();
    chk_rd("ar_reload", 9'h182, 16'd2);
    chk_rd("ar_expired", 9'h183, 16'd1);
    check("ar_irq_masked", {15'd0, irq_a}, 16'd0);
    wr(9'h183, 16'd1);
    chk_rd("ar_clr", 9'h183, 16'd0);
    repeat (3) step();
    chk_rd("ar_count1b", 9'h182, 16'd1);
    chk_rd("ar_still_clr", 9'h183, 16'd0);
    repeat (4) step();
    chk_rd("ar_reload2", 9'h182, 16'd2);
    chk_rd("ar_expired2", 9'h183, 16'd1);

    // Clear on the exact expiry edge: set wins
    wr(9'h183, 16'd1);
    chk_rd("col_pre_clr", 9'h183, 16'd0);
    repeat (6) step();
    wr(9'h183, 16'd1);
    chk_rd("col_set_wins", 9'h183, 16'd1);
    chk_rd("col_reload", 9'h182, 16'd2);

    // LOAD write on a tick cycle: write wins, prescaler restarts
    repeat (3) step();
    wr(9'h181, 16'd7);
    chk_rd("col_load7", 9'h182, 16'd7);
    chk_rd("col_loadreg", 9'h181, 16'd7);
    repeat (3) step();
    chk_rd("col_hold7", 9'h182, 16'd7);
    step();
    chk_rd("col_count6", 9'h182, 16'd6);

    // Pause: EN off on the tick cycle discards the tick, COUNT holds
    repeat (4) step();
    chk_rd("pz_count5", 9'h182, 16'd5);
    repeat (3) step();
    wr(9'h180, 16'h0002);
    chk_rd("pz_tick_drop", 9'h182, 16'd5);
    chk_rd("pz_ctrl", 9'h180, 16'h0002);
    repeat (20) step();
    chk_rd("pz_held", 9'h182, 16'd5);
    wr(9'h180, 16'h0003);
    repeat (3) step();
    chk_rd("pz_resume5", 9'h182, 16'd5);
    step();
    chk_rd("pz_resume4", 9'h182, 16'd4);

    // COUNT is read-only; decode window
    wr(9'h182, 16'h1234);
    chk_rd("cnt_wr_ignored", 9'h182, 16'd4);
    chk_undriven("dec_140", 9'h140);
    chk_undriven("dec_184", 9'h184);
    chk_rd("dec_ctrl", 9'h180, 16'h0003);
    chk_rd("dec_status", 9'h183, 16'h0001);

    // LOAD of 0 while running: HOLD, no expiry
    wr(9'h183, 16'd1);
    wr(9'h181, 16'd0);
    chk_rd("ld0_count", 9'h182, 16'd0);
    chk_rd("ld0_load", 9'h181, 16'd0);
    repeat (8) step();
    chk_rd("ld0_hold", 9'h182, 16'd0);
    chk_rd("ld0_noexp", 9'h183, 16'd0);

    // From HOLD, a nonzero LOAD restarts; one-shot with IRQ_EN
    wr(9'h181, 16'd2);
    wr(9'h180, 16'h0005);
    repeat (2) step();
    chk_rd("hr_count2", 9'h182, 16'd2);
    step();
    chk_rd("hr_count1", 9'h182, 16'd1);
    repeat (4) step();
    chk_rd("hr_count0", 9'h182, 16'd0);
    chk_rd("hr_expired", 9'h183, 16'd1);
    check("hr_irq", {15'd0, irq_a}, 16'd1);

    // Reset mid-count
    wr(9'h181, 16'd9);
    repeat (5) step();
    chk_rd("mr_running", 9'h182, 16'd8);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mr_irq_async", {15'd0, irq_a}, 16'd0);
    chk_undriven("mr_bus_z", 9'h182);
    repeat (2) step();
    reset = 1'b1;
    chk_rd("mr_ctrl", 9'h180, 16'h0000);
    chk_rd("mr_load", 9'h181, 16'h0000);
    chk_rd("mr_count", 9'h182, 16'h0000);
    chk_rd("mr_status", 9'h183, 16'h0000);
    check("mr_irq", {15'd0, irq_a}, 16'd0);
    repeat (10) step();
    chk_rd("mr_count_after", 9'h182, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
